// File: rtl/data_mem_responder_pkg.sv
// Shared encodings for the data memory responder: access sizes, FSM states
// and the wait-state counter width.
package data_mem_responder_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering for stores, write-mask generation, load extraction with
// sign/zero extension, and size/alignment fault detection.
module dmem_lane_align
    import data_mem_responder_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  addr_lo,
    input  logic        is_unsigned,
    input  logic [31:0] wdata,
    input  logic [31:0] rword,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    output logic [31:0] ld_data,
    output logic        align_fault
);

    logic [31:0] shifted;

    always_comb begin
        wr_data     = '0;
        wr_mask     = '0;
        ld_data     = '0;
        align_fault = 1'b0;
        shifted     = rword >> {addr_lo, 3'b000};
        case (size)
            SZ_BYTE: begin
                wr_data = {4{wdata[7:0]}};
                wr_mask = 4'b0001 << addr_lo;
                ld_data = is_unsigned ? {24'd0, shifted[7:0]}
                                      : {{24{shifted[7]}}, shifted[7:0]};
            end
            SZ_HALF: begin
                align_fault = addr_lo[0];
                wr_data     = {2{wdata[15:0]}};
                wr_mask     = addr_lo[1] ? 4'b1100 : 4'b0011;
                ld_data     = is_unsigned ? {16'd0, shifted[15:0]}
                                          : {{16{shifted[15]}}, shifted[15:0]};
            end
            SZ_WORD: begin
                align_fault = (addr_lo != 2'b00);
                wr_data     = wdata;
                wr_mask     = 4'b1111;
                ld_data     = rword;
            end
            default: align_fault = 1'b1;
        endcase
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-port data memory with a load/store request handshake, fixed wait
// states, lane-aware stores, extended loads and an independent debug read.
//
// state   | meaning
// IDLE    | ready for a request
// WAIT    | counting wait states; access performed on the last one
// RESP    | one-cycle response pulse
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        sys_clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    input  logic [1:0]  req_size_i,
    input  logic        req_unsigned_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    input  logic        dbg_rd_en_i,
    input  logic [31:0] dbg_rd_addr_i,
    output logic [31:0] dbg_rd_data_o
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYCLES);

    state_t                state;
    logic [WAIT_CNT_W-1:0] wait_cnt;

    logic        lat_we, lat_unsigned;
    logic [31:0] lat_addr, lat_wdata;
    logic [1:0]  lat_size;

    logic        accept, acc_en;
    logic        acc_we, acc_unsigned;
    logic [31:0] acc_addr, acc_wdata;
    logic [1:0]  acc_size;
    logic [IDX_W-1:0] acc_idx;
    logic        acc_in_range, acc_fault, align_fault;

    logic [31:0] rd_word, wr_data, ld_data;
    logic [3:0]  wr_mask;

    logic [IDX_W-1:0] dbg_idx;
    logic        dbg_in_range;
    logic        unused_dbg_lo;

    logic [31:0] mem [DEPTH_WORDS];

    assign accept = req_valid_i && req_ready_o && !rst_i;

    // With no wait states the access happens on the accept edge itself, so
    // it must use the live request rather than the latched copy.
    assign acc_we       = (WAIT_CYCLES == 0) ? req_we_i       : lat_we;
    assign acc_addr     = (WAIT_CYCLES == 0) ? req_addr_i     : lat_addr;
    assign acc_wdata    = (WAIT_CYCLES == 0) ? req_wdata_i    : lat_wdata;
    assign acc_size     = (WAIT_CYCLES == 0) ? req_size_i     : lat_size;
    assign acc_unsigned = (WAIT_CYCLES == 0) ? req_unsigned_i : lat_unsigned;
    assign acc_en       = (WAIT_CYCLES == 0) ? accept
                        : (state == ST_WAIT && wait_cnt == WAIT_CNT_W'(1));

    assign acc_idx      = acc_addr[IDX_W+1:2];
    assign acc_in_range = (acc_addr[31:IDX_W+2] == '0);
    assign acc_fault    = align_fault || !acc_in_range;
    assign rd_word      = mem[acc_idx];

    dmem_lane_align u_lane_align (
        .size        (acc_size),
        .addr_lo     (acc_addr[1:0]),
        .is_unsigned (acc_unsigned),
        .wdata       (acc_wdata),
        .rword       (rd_word),
        .wr_data     (wr_data),
        .wr_mask     (wr_mask),
        .ld_data     (ld_data),
        .align_fault (align_fault)
    );

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            wait_cnt     <= '0;
            req_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_rdata_o  <= '0;
            rsp_err_o    <= 1'b0;
            lat_we       <= 1'b0;
            lat_addr     <= '0;
            lat_wdata    <= '0;
            lat_size     <= SZ_BYTE;
            lat_unsigned <= 1'b0;
        end else begin
            rsp_valid_o <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        lat_we       <= req_we_i;
                        lat_addr     <= req_addr_i;
                        lat_wdata    <= req_wdata_i;
                        lat_size     <= req_size_i;
                        lat_unsigned <= req_unsigned_i;
                        wait_cnt     <= WAIT_LOAD;
                        req_ready_o  <= 1'b0;
                        state        <= (WAIT_CYCLES == 0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 1'b1;
                    if (wait_cnt == WAIT_CNT_W'(1)) begin
                        state <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
                default: begin
                    state       <= ST_IDLE;
                    req_ready_o <= 1'b1;
                end
            endcase
            if (acc_en) begin
                rsp_valid_o <= 1'b1;
                rsp_err_o   <= acc_fault;
                rsp_rdata_o <= (acc_fault || acc_we) ? 32'd0 : ld_data;
            end
        end
    end

    // Storage is deliberately not reset; reset only aborts by returning to IDLE.
    always_ff @(posedge sys_clk_i) begin
        if (acc_en && acc_we && !acc_fault) begin
            for (int i = 0; i < 4; i++) begin
                if (wr_mask[i]) begin
                    mem[acc_idx][i*8 +: 8] <= wr_data[i*8 +: 8];
                end
            end
        end
    end

    assign dbg_idx       = dbg_rd_addr_i[IDX_W+1:2];
    assign dbg_in_range  = (dbg_rd_addr_i[31:IDX_W+2] == '0);
    assign unused_dbg_lo = ^dbg_rd_addr_i[1:0];

    always_ff @(posedge sys_clk_i or posedge rst_i) begin
        if (rst_i) begin
            dbg_rd_data_o <= '0;
        end else if (dbg_rd_en_i) begin
            dbg_rd_data_o <= dbg_in_range ? mem[dbg_idx] : 32'd0;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized and directed bench for data_mem_responder against a byte-array
// reference model of the load/store rules.
module tb_data_mem_responder;

    localparam int DEPTH = 64;
    localparam int WAITC = 1;

    logic        sys_clk_i = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_we_i;
    logic [31:0] req_addr_i;
    logic [31:0] req_wdata_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i;
    logic        rsp_valid_o;
    logic [31:0] rsp_rdata_o;
    logic        rsp_err_o;
    logic        dbg_rd_en_i;
    logic [31:0] dbg_rd_addr_i;
    logic [31:0] dbg_rd_data_o;

    always #5 sys_clk_i = ~sys_clk_i;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .sys_clk_i      (sys_clk_i),
        .rst_i          (rst_i),
        .req_valid_i    (req_valid_i),
        .req_ready_o    (req_ready_o),
        .req_we_i       (req_we_i),
        .req_addr_i     (req_addr_i),
        .req_wdata_i    (req_wdata_i),
        .req_size_i     (req_size_i),
        .req_unsigned_i (req_unsigned_i),
        .rsp_valid_o    (rsp_valid_o),
        .rsp_rdata_o    (rsp_rdata_o),
        .rsp_err_o      (rsp_err_o),
        .dbg_rd_en_i    (dbg_rd_en_i),
        .dbg_rd_addr_i  (dbg_rd_addr_i),
        .dbg_rd_data_o  (dbg_rd_data_o)
    );

    logic [7:0] ref_bytes [DEPTH*4];
    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, n = 2**size bytes per access.
    task automatic ref_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [1:0] size, input logic uns,
                              output logic [31:0] rdata, output logic err);
        int n;
        longint v;
        err = (size == 2'd3) || (size == 2'd1 && addr % 2 != 0) ||
              (size == 2'd2 && addr % 4 != 0) || (addr / 4 >= DEPTH);
        rdata = 32'd0;
        if (!err) begin
            n = 1 << size;
            if (we) begin
                for (int k = 0; k < n; k++)
                    ref_bytes[addr + k] = 8'(wdata >> (8 * k));
            end else begin
                v = 0;
                for (int k = 0; k < n; k++)
                    v = v + (longint'(ref_bytes[addr + k]) << (8 * k));
                if (!uns && ((v >> (8 * n - 1)) & 1) == 1)
                    v = v - (longint'(1) << (8 * n));
                rdata = 32'(v);
            end
        end
    endtask

    function automatic logic [31:0] ref_word(input logic [31:0] addr);
        logic [31:0] a;
        a = addr & ~32'd3;
        if (addr / 4 >= DEPTH) return 32'd0;
        return {ref_bytes[a + 3], ref_bytes[a + 2], ref_bytes[a + 1], ref_bytes[a]};
    endfunction

    task automatic do_req(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                          output logic [31:0] rdata, output logic err);
        logic [31:0] exp_d;
        logic        exp_e;
        int          guard;
        int          lat;
        ref_access(we, addr, wdata, size, uns, exp_d, exp_e);
        @(negedge sys_clk_i);
        guard = 0;
        while (!req_ready_o && guard < 20) begin
            @(negedge sys_clk_i);
            guard++;
        end
        check_val({tag, "_ready"}, 32'(req_ready_o), 32'd1);
        req_valid_i = 1'b1; req_we_i = we; req_addr_i = addr;
        req_wdata_i = wdata; req_size_i = size; req_unsigned_i = uns;
        @(posedge sys_clk_i);
        #1;
        req_valid_i = 1'b0; req_we_i = 1'($urandom); req_addr_i = $urandom;
        req_wdata_i = $urandom; req_size_i = 2'($urandom); req_unsigned_i = 1'($urandom);
        lat = 0;
        do begin
            @(negedge sys_clk_i);
            lat++;
        end while (!rsp_valid_o && lat < 20);
        check_val({tag, "_lat"}, 32'(lat), 32'(WAITC + 1));
        check_val({tag, "_data"}, rsp_rdata_o, exp_d);
        check_val({tag, "_err"}, 32'(rsp_err_o), 32'(exp_e));
        rdata = rsp_rdata_o;
        err   = rsp_err_o;
        @(negedge sys_clk_i);
        check_val({tag, "_pulse"}, 32'(rsp_valid_o), 32'd0);
        check_val({tag, "_hold"}, rsp_rdata_o, exp_d);
    endtask

    task automatic dbg_check(input string tag, input logic [31:0] addr);
        @(negedge sys_clk_i);
        dbg_rd_en_i = 1'b1; dbg_rd_addr_i = addr;
        @(posedge sys_clk_i);
        #1;
        dbg_rd_en_i = 1'b0; dbg_rd_addr_i = $urandom;
        @(negedge sys_clk_i);
        check_val({tag, "_dbg"}, dbg_rd_data_o, ref_word(addr));
        @(negedge sys_clk_i);
        check_val({tag, "_dbghold"}, dbg_rd_data_o, ref_word(addr));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] d, a, w0;
        logic        e, we, uns;
        logic [1:0]  sz;
        int          acc, pulses;

        rst_i = 1'b1; req_valid_i = 1'b0; req_we_i = 1'b0; req_addr_i = '0;
        req_wdata_i = '0; req_size_i = '0; req_unsigned_i = 1'b0;
        dbg_rd_en_i = 1'b0; dbg_rd_addr_i = '0;
        repeat (3) @(negedge sys_clk_i);
        check_val("rst_ready", 32'(req_ready_o), 32'd1);
        check_val("rst_valid", 32'(rsp_valid_o), 32'd0);
        check_val("rst_rdata", rsp_rdata_o, 32'd0);
        check_val("rst_err", 32'(rsp_err_o), 32'd0);
        check_val("rst_dbg", dbg_rd_data_o, 32'd0);
        rst_i = 1'b0;

        for (int w = 0; w < DEPTH; w++)
            do_req("init", 1'b1, 32'(w * 4), $urandom, 2'd2, 1'b0, d, e);

        do_req("st_word", 1'b1, 32'h10, 32'hDEADBEEF, 2'd2, 1'b0, d, e);
        check_val("st_word_zero", d, 32'd0);
        do_req("ld_word", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, e);
        check_val("ld_word_const", d, 32'hDEADBEEF);
        do_req("ld_sbyte", 1'b0, 32'h13, 32'h0, 2'd0, 1'b0, d, e);
        check_val("ld_sbyte_const", d, 32'hFFFFFFDE);
        do_req("ld_uhalf", 1'b0, 32'h12, 32'h0, 2'd1, 1'b1, d, e);
        check_val("ld_uhalf_const", d, 32'h0000DEAD);
        do_req("st_byte", 1'b1, 32'h11, 32'hAAAAAA55, 2'd0, 1'b0, d, e);
        do_req("ld_part", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, e);
        check_val("ld_part_const", d, 32'hDEAD55EF);

        w0 = ref_word(32'h0);
        do_req("f_word", 1'b0, 32'h12, 32'h0, 2'd2, 1'b0, d, e);
        check_val("f_word_err", 32'(e), 32'd1);
        do_req("f_half", 1'b1, 32'h11, 32'h12345678, 2'd1, 1'b0, d, e);
        check_val("f_half_err", 32'(e), 32'd1);
        do_req("f_range", 1'b1, 32'(DEPTH * 4), 32'h0BADF00D, 2'd2, 1'b0, d, e);
        check_val("f_range_err", 32'(e), 32'd1);
        do_req("f_size", 1'b1, 32'h10, 32'h0BADF00D, 2'd3, 1'b0, d, e);
        do_req("f_chk10", 1'b0, 32'h10, 32'h0, 2'd2, 1'b0, d, e);
        check_val("f_chk10_const", d, 32'hDEAD55EF);
        do_req("f_chk0", 1'b0, 32'h0, 32'h0, 2'd2, 1'b0, d, e);
        check_val("f_chk0_word", d, w0);

        // Store commits on the edge after accept; debug read on that edge sees old data.
        @(negedge sys_clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h10;
        req_wdata_i = 32'h12345678; req_size_i = 2'd2; req_unsigned_i = 1'b0;
        @(posedge sys_clk_i);
        #1;
        req_valid_i = 1'b0;
        repeat (WAITC - 1) @(posedge sys_clk_i);
        dbg_rd_en_i = 1'b1; dbg_rd_addr_i = 32'h10;
        @(posedge sys_clk_i);
        @(negedge sys_clk_i);
        check_val("coll_old", dbg_rd_data_o, 32'hDEAD55EF);
        check_val("coll_rsp", 32'(rsp_valid_o), 32'd1);
        @(posedge sys_clk_i);
        #1;
        dbg_rd_en_i = 1'b0;
        @(negedge sys_clk_i);
        check_val("coll_new", dbg_rd_data_o, 32'h12345678);
        ref_access(1'b1, 32'h10, 32'h12345678, 2'd2, 1'b0, d, e);

        // Continuous valid: one accept per WAITC+2 cycles.
        @(negedge sys_clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b0; req_addr_i = 32'h10;
        req_size_i = 2'd2; req_unsigned_i = 1'b0;
        acc = 0;
        for (int i = 0; i < 4 * (WAITC + 2); i++) begin
            check_val($sformatf("hs_ready%0d", i), 32'(req_ready_o), 32'((i % (WAITC + 2)) == 0));
            check_val($sformatf("hs_valid%0d", i), 32'(rsp_valid_o), 32'((i % (WAITC + 2)) == WAITC + 1));
            if (req_ready_o) acc++;
            @(negedge sys_clk_i);
        end
        req_valid_i = 1'b0;
        check_val("hs_accepts", 32'(acc), 32'd4);

        // Reset during WAIT of a store aborts it.
        @(negedge sys_clk_i);
        req_valid_i = 1'b1; req_we_i = 1'b1; req_addr_i = 32'h20;
        req_wdata_i = 32'hCAFEF00D; req_size_i = 2'd2;
        @(posedge sys_clk_i);
        #1;
        req_valid_i = 1'b0;
        @(negedge sys_clk_i);
        check_val("ab_inwait", 32'(req_ready_o), 32'd0);
        rst_i = 1'b1;
        #1;
        check_val("ab_ready", 32'(req_ready_o), 32'd1);
        check_val("ab_valid", 32'(rsp_valid_o), 32'd0);
        check_val("ab_rdata", rsp_rdata_o, 32'd0);
        check_val("ab_err", 32'(rsp_err_o), 32'd0);
        check_val("ab_dbg", dbg_rd_data_o, 32'd0);
        @(negedge sys_clk_i);
        rst_i = 1'b0;
        pulses = 0;
        repeat (5) begin
            @(negedge sys_clk_i);
            if (rsp_valid_o) pulses++;
        end
        check_val("ab_pulses", 32'(pulses), 32'd0);
        do_req("ab_chk", 1'b0, 32'h20, 32'h0, 2'd2, 1'b0, d, e);

        for (int i = 0; i < 200; i++) begin
            we  = 1'($urandom);
            uns = 1'($urandom);
            sz  = ($urandom_range(7, 0) == 0) ? 2'd3 : 2'($urandom_range(2, 0));
            a   = ($urandom_range(9, 0) == 0) ? $urandom : 32'($urandom_range(DEPTH * 4 - 1, 0));
            if ($urandom_range(3, 0) != 0) begin
                if (sz == 2'd1) a[0] = 1'b0;
                if (sz == 2'd2) a[1:0] = 2'b00;
            end
            do_req($sformatf("rnd%0d", i), we, a, $urandom, sz, uns, d, e);
            if (i % 8 == 0)
                dbg_check($sformatf("rdbg%0d", i), 32'($urandom_range(DEPTH * 4 + 63, 0)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
